// File: rtl/uart_mux_arbiter.sv
// Round-robin arbiter that drains per-channel RX fifos into a single UART TX,
// optionally prefixing each burst with a 0xF0|channel header byte.
module uart_mux_arbiter #(
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned TAG_ENABLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   fifo_empty,
  input  logic [8*CHANNELS-1:0] fifo_data,
  output logic [CHANNELS-1:0]   fifo_read,
  input  logic                  tx_ready,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic [CHANNELS-1:0]   grant,
  output logic                  busy
);

  localparam int unsigned IW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_GAP    = 2'd3;

  logic [1:0]          state, state_nxt;
  logic [IW-1:0]       gidx, gidx_nxt;
  logic [IW-1:0]       ptr, ptr_nxt;
  logic [CW-1:0]       count, count_nxt;
  logic                from_hdr, from_hdr_nxt;
  logic [CHANNELS-1:0] grant_nxt;

  logic                head_empty;
  logic [7:0]          head_data;
  logic                scan_found;
  logic [IW-1:0]       scan_idx;
  logic [SW-1:0]       cand;

  // Head word and empty flag of the currently granted channel
  always_comb begin
    head_empty = 1'b1;
    head_data  = 8'h00;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (IW'(i) == gidx) begin
        head_empty = fifo_empty[i];
        head_data  = fifo_data[8*i +: 8];
      end
    end
  end

  // First non-empty channel scanning upward from ptr+1 with wrap
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      cand = SW'(ptr) + SW'(k);
      if (cand >= SW'(CHANNELS)) begin
        cand = cand - SW'(CHANNELS);
      end
      for (int unsigned j = 0; j < CHANNELS; j++) begin
        if (!scan_found && (SW'(j) == cand) && !fifo_empty[j]) begin
          scan_found = 1'b1;
          scan_idx   = IW'(j);
        end
      end
    end
  end

  // Next-state and combinational TX/fifo strobes
  always_comb begin
    state_nxt    = state;
    gidx_nxt     = gidx;
    ptr_nxt      = ptr;
    count_nxt    = count;
    from_hdr_nxt = from_hdr;
    grant_nxt    = grant;
    tx_start     = 1'b0;
    tx_data      = 8'h00;
    fifo_read    = '0;

    case (state)
      S_IDLE: begin
        if (scan_found) begin
          gidx_nxt  = scan_idx;
          count_nxt = '0;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            grant_nxt[i] = (IW'(i) == scan_idx);
          end
          state_nxt = (TAG_ENABLE != 0) ? S_HEADER : S_SEND;
        end
      end

      S_HEADER: begin
        if (tx_ready) begin
          tx_start     = 1'b1;
          tx_data      = {4'hF, gidx};
          from_hdr_nxt = 1'b1;
          state_nxt    = S_GAP;
        end
      end

      S_SEND: begin
        if (head_empty) begin
          ptr_nxt   = gidx;
          grant_nxt = '0;
          state_nxt = S_IDLE;
        end else if (tx_ready) begin
          tx_start = 1'b1;
          tx_data  = head_data;
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            fifo_read[i] = (IW'(i) == gidx);
          end
          count_nxt    = count + CW'(1);
          from_hdr_nxt = 1'b0;
          state_nxt    = S_GAP;
        end
      end

      S_GAP: begin
        if (from_hdr) begin
          from_hdr_nxt = 1'b0;
          state_nxt    = S_SEND;
        end else if ((count == CW'(BURST_MAX)) || head_empty) begin
          ptr_nxt   = gidx;
          grant_nxt = '0;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_SEND;
        end
      end

      default: begin
        grant_nxt = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, grant and bookkeeping registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      gidx     <= '0;
      ptr      <= IW'(CHANNELS - 1);
      count    <= '0;
      from_hdr <= 1'b0;
      grant    <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gidx     <= gidx_nxt;
      ptr      <= ptr_nxt;
      count    <= count_nxt;
      from_hdr <= from_hdr_nxt;
      grant    <= grant_nxt;
      busy     <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: doc/uart_mux_arbiter.md
Name: uart_mux_arbiter

Overview:
- Round-robin scheduler that drains CHANNELS per-channel RX fifos into one shared UART transmitter.
- Grants one channel at a time and optionally emits a header byte (0xF0 | channel) ahead of each burst.
- Sends up to BURST_MAX payload bytes per grant, then moves to the next non-empty channel.
- Sits between the fifo instances (read/empty/read_data side) and the UART TX core.

Parameters:
- CHANNELS, 4, number of requesting fifos; legal range 2..16.
- BURST_MAX, 4, max payload bytes sent per grant; legal range 1..255.
- TAG_ENABLE, 1, 1 = send header byte before each burst; 0 = payload only.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  CHANNELS  per-channel fifo empty flag.
- fifo_data  in  8*CHANNELS  per-channel fifo head word; channel i at bits [8i+7:8i].
- fifo_read  out  CHANNELS  one-cycle pop strobe per channel.
- tx_ready  in  1  UART TX idle, able to accept a byte.
- tx_start  out  1  one-cycle byte-issue strobe to UART TX.
- tx_data  out  8  byte to transmit; valid while tx_start=1.
- grant  out  CHANNELS  one-hot current owner; all zero when idle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, grant=0, busy=0, burst count=0.
  - Last-served pointer = CHANNELS-1, so channel 0 has first priority.
  - tx_start, fifo_read and tx_data read 0 while in IDLE.
  - Deassertion takes effect at the next rising edge.
- Fifo contract: fifo_data[i] shows the head word whenever fifo_empty[i]=0. A fifo_read pulse pops it; new head and empty flag are visible the following cycle.
- TX contract:
  - The byte is accepted on the edge where tx_start=1.
  - The transmitter drops tx_ready no later than the next cycle and holds it low until the byte completes.
- tx_start, tx_data and fifo_read are combinational from registered state plus inputs. grant and busy are registered.
- FSM states: IDLE, HEADER, SEND, GAP.
  - IDLE: if any fifo_empty bit is 0, pick the first non-empty channel scanning upward from pointer+1 with wrap. Latch it into grant, clear count, then go to HEADER (TAG_ENABLE=1) or SEND. Otherwise stay.
  - HEADER:
    - If tx_ready=1: tx_start=1, tx_data = {4'hF, channel index[3:0]}, go to GAP.
    - Else hold; no outputs asserted.
  - SEND:
    - If tx_ready=1 and fifo_empty[g]=0: tx_start=1, tx_data=fifo_data[g], fifo_read[g]=1, count+1, go to GAP.
    - If fifo_empty[g]=1: go to IDLE and update pointer=g.
    - Else hold.
  - GAP: exactly one cycle, tx_ready ignored. Then:
    - Came from HEADER → SEND.
    - Else if count==BURST_MAX or fifo_empty[g]=1 → IDLE, pointer=g, grant cleared.
    - Else → SEND.
- Timing: at most one tx_start per two cycles. With tx_ready constantly high, one burst is header + payload bytes on cycles t, t+2, t+4, …
- Arbitration is non-preemptive: requests on other channels during a burst wait. Fairness: each channel is served within CHANNELS grants.
- Boundary cases:
  - Channel empties mid-burst: burst ends cleanly after GAP; a header with zero payload never occurs because grant requires non-empty at IDLE.
  - Pointer wraps CHANNELS-1 → 0.
  - A single active channel is regranted after a one-cycle IDLE, with a new header each burst.
  - Reset mid-burst: all outputs drop immediately, no pop. A byte already accepted by the TX is lost to the arbiter's accounting.
- Invariants: fifo_read is never asserted for a non-granted or empty channel. fifo_read is at most one-hot. fifo_read implies tx_start.

Test Plan:
- Reset: hold reset=0 with fifos non-empty → tx_start=0, fifo_read=0, grant=0, busy=0. Release → grant=4'b0001 on the first edge.
- Single channel, TAG_ENABLE=1: ch2 holds 0x88, 0x33; tx_ready=1 → tx_data sequence 0xF2, 0x88, 0x33 on cycles t, t+2, t+4. Exactly two fifo_read[2] pulses, then IDLE.
- Burst limit: ch0 holds 6 bytes 0x01..0x06, ch1 holds 0xAA, BURST_MAX=4 → F0,01,02,03,04, F1,AA, F0,05,06.
- Backpressure: hold tx_ready=0 for 20 cycles in SEND → no tx_start and no pop. Raise it → the next byte issues on that same cycle.
- Round-robin wrap: ch3 and ch0 non-empty, last served = ch3 → ch0 granted before ch3.
- Reset mid-burst: assert reset during GAP of a 4-byte burst → outputs 0 at once. After release, the channel restarts with a header and the remaining fifo bytes.
